// File: rtl/pipe_skid_reg_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared constants and state encoding for the pipeline skid
//               register and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package pipe_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned CNT_W_DEF = 32;

    // Encoding is {out_valid, skid_valid}; 2'b01 cannot occur.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL1 = 2'b10,
        ST_FULL2 = 2'b11
    } state_e;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_skid_reg_if.sv
// ============================================================================
// Module      : pipe_skid_reg_if
// Description : Upstream/downstream handshake bundle of the skid register.
//               master drives the block's inputs, slave is the block itself.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface pipe_skid_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;

    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data
    );

endinterface : pipe_skid_reg_if

`default_nettype wire

// File: rtl/pipe_skid_reg_sat_cnt.sv
// ============================================================================
// Module      : pipe_sat_cnt
// Description : Up counter with enable that sticks at all-ones; cleared only
//               by the asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pipe_sat_cnt
    import pipe_pkg::*;
#(
    parameter int unsigned W = CNT_W_DEF
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         en_i,
    output logic [W-1:0]      cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : pipe_sat_cnt

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// ============================================================================
// Module      : pipe_skid_reg
// Description : Inter-stage register with valid/ready, 2-entry skid and
//               flush. Optional stall counter enabled by PIPE_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned     WIDTH     = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned     CNT_W     = CNT_W_DEF
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    pipe_skid_reg_if.slave        pipe,
    output logic [CNT_W-1:0]      stall_cnt
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_ready_q, in_ready_d;
    logic             accept;
    logic             consume;

    assign accept  = pipe.in_valid & in_ready_q;
    assign consume = state_q[1] & pipe.out_ready;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;

        // Flush wins outright: nothing is loaded, data registers keep contents.
        if (pipe.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_data_d = pipe.in_data;
                        state_d    = ST_FULL1;
                    end
                end
                ST_FULL1: begin
                    if (accept && consume) begin
                        out_data_d = pipe.in_data;
                    end else if (accept) begin
                        skid_data_d = pipe.in_data;
                        state_d     = ST_FULL2;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL2: begin
                    if (consume) begin
                        out_data_d = skid_data_q;
                        state_d    = ST_FULL1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        in_ready_d = ~state_d[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_data_q  <= RESET_VAL;
            skid_data_q <= RESET_VAL;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign pipe.out_valid = state_q[1];
    assign pipe.out_data  = out_data_q;
    assign pipe.in_ready  = in_ready_q;

`ifdef PIPE_STALL_CNT_EN
    pipe_sat_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (pipe.in_valid & ~in_ready_q),
        .cnt_o (stall_cnt)
    );
`else
    assign stall_cnt = '0;
`endif

endmodule : pipe_skid_reg

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ============================================================================
// Module      : tb_pipe_skid_reg
// Description : Directed + random bench for pipe_skid_reg against a 2-deep
//               queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pipe_skid_reg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;
    localparam int          STALL_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_skid_reg_if #(.WIDTH(WIDTH)) bus ();

    pipe_skid_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL ('0),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pipe      (bus),
        .stall_cnt (stall_cnt)
    );

    // Reference model: a FIFO of at most two payloads plus the last head seen.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_last;
    int               m_stall;
    int               n_checks = 0;
    int               n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_last  = '0;
        m_stall = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [WIDTH-1:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : m_last;
        chk_eq({tag, ".out_valid"}, 64'(bus.out_valid), 64'(mq.size() > 0));
        chk_eq({tag, ".in_ready"},  64'(bus.in_ready),  64'(mq.size() < 2));
        chk_eq({tag, ".out_data"},  64'(bus.out_data),  64'(exp_data));
`ifdef PIPE_STALL_CNT_EN
        chk_eq({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
`else
        chk_eq({tag, ".stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
        if (mq.size() > 0) m_last = mq[0];
    endtask

    // Called right after a negedge; applies inputs, advances model, checks.
    task automatic step(input logic v, input logic [WIDTH-1:0] d,
                        input logic ordy, input logic fl, input string tag);
        bit acc, con;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        acc = v && (mq.size() < 2);
        con = (mq.size() > 0) && ordy;
        if (v && !(mq.size() < 2) && m_stall < STALL_MAX) m_stall++;
        if (fl) begin
            mq.delete();
        end else begin
            if (con) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEAD_BEEF;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");

        rst_n = 1'b1;
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, "reset_release");
        step(1'b0, '0, 1'b1, 1'b0, "drain0");

        for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b1, 1'b0, "stream");
        step(1'b0, '0, 1'b1, 1'b0, "stream_end");

        step(1'b1, 32'hA, 1'b0, 1'b0, "bp_a");
        step(1'b1, 32'hB, 1'b0, 1'b0, "bp_b");
        step(1'b1, 32'hC, 1'b0, 1'b0, "bp_hold");
        repeat (3) step(1'b1, 32'hC, 1'b1, 1'b0, "bp_drain");
        step(1'b0, '0, 1'b1, 1'b0, "bp_end");

        step(1'b1, 32'hA, 1'b0, 1'b0, "fl_a");
        step(1'b1, 32'hB, 1'b0, 1'b0, "fl_b");
        step(1'b1, 32'hC, 1'b0, 1'b1, "fl_flush");
        repeat (3) step(1'b0, '0, 1'b1, 1'b0, "fl_after");

        step(1'b1, 32'h11, 1'b0, 1'b0, "ar_a");
        step(1'b1, 32'h22, 1'b0, 1'b0, "ar_b");
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        repeat (20) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0, "stall");
        repeat (3) step(1'b0, '0, 1'b1, 1'b0, "stall_drain");

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, WIDTH'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_skid_reg

`default_nettype wire
